// File: rtl/rgb_ordered_dither.sv
// -----------------------------------------------------------------------------
// rgb_ordered_dither
//
// Final colour stage ahead of the resistor-ladder VGA DAC. Each 6-bit channel
// is reduced to OUT_BITS bits with a 2x2 ordered (Bayer) dither. Pixel/line
// phase is recovered from the sync and blank inputs. Sync and blank travel
// through the same two-stage pipeline as colour, so the block drops in-line
// in front of the video pins without introducing skew.
//
// Optional feature (compile-time macro TEMPORAL_DITHER_EN): adds a frame
// parity bit that flips the column phase every frame so the dither texture
// alternates between frames instead of standing still.
//
// Parameters:
//   OUT_BITS   output bits per channel, 1..6 (D = 6 - OUT_BITS bits dropped)
//
// Ports:
//   clk        master video clock
//   rst_n      asynchronous active-low reset
//   pixel_ce   pixel clock enable; all state advances only when high
//   dither_en  1 = ordered dither, 0 = plain truncation
//   hsync_n_i  horizontal sync in, active low
//   vsync_n_i  vertical sync in, active low
//   blank_i    1 = outside active video
//   ri/gi/bi   6-bit colour in
//   ro/go/bo   OUT_BITS colour out, forced to 0 while blanked
//   hsync_n_o  hsync delayed to align with colour
//   vsync_n_o  vsync delayed to align with colour
//   blank_o    blank delayed to align with colour
// -----------------------------------------------------------------------------
module rgb_ordered_dither #(
    parameter int OUT_BITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pixel_ce,
    input  logic                dither_en,
    input  logic                hsync_n_i,
    input  logic                vsync_n_i,
    input  logic                blank_i,
    input  logic [5:0]          ri,
    input  logic [5:0]          gi,
    input  logic [5:0]          bi,
    output logic [OUT_BITS-1:0] ro,
    output logic [OUT_BITS-1:0] go,
    output logic [OUT_BITS-1:0] bo,
    output logic                hsync_n_o,
    output logic                vsync_n_o,
    output logic                blank_o
);

    localparam int D = 6 - OUT_BITS;

    // Phase tracking
    logic hs_prev_q, hs_prev_d;
    logic vs_prev_q, vs_prev_d;
    logic col_par_q, col_par_d;
    logic row_par_q, row_par_d;
`ifdef TEMPORAL_DITHER_EN
    logic frame_par_q, frame_par_d;
`endif

    // Stage 1
    logic [5:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d, t1_q, t1_d;
    logic       hs1_q, hs1_d, vs1_q, vs1_d, blank1_q, blank1_d;

    // Stage 2
    logic [OUT_BITS-1:0] ro_q, ro_d, go_q, go_d, bo_q, bo_d;
    logic                hs2_q, hs2_d, vs2_q, vs2_d, blank2_q, blank2_d;

    logic       hs_fall, vs_fall;
    logic [1:0] bayer_idx;
    logic [1:0] bayer_val;
    logic [5:0] t_cur;
    logic [5:0] t_eff;

    // Edge registers idle high, so a sync already low out of reset is not an edge.
    assign hs_fall = hs_prev_q & ~hsync_n_i;
    assign vs_fall = vs_prev_q & ~vsync_n_i;

`ifdef TEMPORAL_DITHER_EN
    assign bayer_idx = {row_par_q, col_par_q ^ frame_par_q};
`else
    assign bayer_idx = {row_par_q, col_par_q};
`endif

    always_comb begin
        case (bayer_idx)
            2'b00:   bayer_val = 2'd0;
            2'b01:   bayer_val = 2'd2;
            2'b10:   bayer_val = 2'd3;
            default: bayer_val = 2'd1;
        endcase
    end

    // Scale the 2-bit Bayer value so its range spans the dropped LSBs.
    generate
        if (D >= 2) begin : g_t_shift
            assign t_cur = 6'(bayer_val) << (D - 2);
        end else if (D == 1) begin : g_t_half
            assign t_cur = {5'b0, bayer_val[1]};
        end else begin : g_t_none
            assign t_cur = '0;
        end
    endgenerate

    assign t_eff = dither_en ? t1_q : 6'd0;

    // Add threshold, drop D LSBs, saturate when the 7-bit sum exceeds 63.
    function automatic logic [OUT_BITS-1:0] quantise(input logic [5:0] c,
                                                     input logic [5:0] t);
        logic [6:0] s;
        s = {1'b0, c} + {1'b0, t};
        return s[6] ? '1 : OUT_BITS'(s >> D);
    endfunction

    // NOTE: every _d starts as its _q so the block holds (no latch) when pixel_ce is low.
    always_comb begin
        hs_prev_d = hs_prev_q;
        vs_prev_d = vs_prev_q;
        col_par_d = col_par_q;
        row_par_d = row_par_q;
`ifdef TEMPORAL_DITHER_EN
        frame_par_d = frame_par_q;
`endif
        r1_d = r1_q; g1_d = g1_q; b1_d = b1_q; t1_d = t1_q;
        hs1_d = hs1_q; vs1_d = vs1_q; blank1_d = blank1_q;
        ro_d = ro_q; go_d = go_q; bo_d = bo_q;
        hs2_d = hs2_q; vs2_d = vs2_q; blank2_d = blank2_q;

        if (pixel_ce) begin
            hs_prev_d = hsync_n_i;
            vs_prev_d = vsync_n_i;

            if (hs_fall)       col_par_d = 1'b0;
            else if (!blank_i) col_par_d = ~col_par_q;

            // Frame start wins over line start when both edges coincide.
            if (vs_fall)       row_par_d = 1'b0;
            else if (hs_fall)  row_par_d = ~row_par_q;

`ifdef TEMPORAL_DITHER_EN
            if (vs_fall)       frame_par_d = ~frame_par_q;
`endif

            r1_d     = ri;
            g1_d     = gi;
            b1_d     = bi;
            t1_d     = t_cur;
            hs1_d    = hsync_n_i;
            vs1_d    = vsync_n_i;
            blank1_d = blank_i;

            ro_d     = blank1_q ? '0 : quantise(r1_q, t_eff);
            go_d     = blank1_q ? '0 : quantise(g1_q, t_eff);
            bo_d     = blank1_q ? '0 : quantise(b1_q, t_eff);
            hs2_d    = hs1_q;
            vs2_d    = vs1_q;
            blank2_d = blank1_q;
        end
    end

    // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
            col_par_q <= 1'b0;
            row_par_q <= 1'b0;
`ifdef TEMPORAL_DITHER_EN
            frame_par_q <= 1'b0;
`endif
            r1_q <= '0; g1_q <= '0; b1_q <= '0; t1_q <= '0;
            hs1_q <= 1'b1; vs1_q <= 1'b1; blank1_q <= 1'b1;
            ro_q <= '0; go_q <= '0; bo_q <= '0;
            hs2_q <= 1'b1; vs2_q <= 1'b1; blank2_q <= 1'b1;
        end else begin
            hs_prev_q <= hs_prev_d;
            vs_prev_q <= vs_prev_d;
            col_par_q <= col_par_d;
            row_par_q <= row_par_d;
`ifdef TEMPORAL_DITHER_EN
            frame_par_q <= frame_par_d;
`endif
            r1_q <= r1_d; g1_q <= g1_d; b1_q <= b1_d; t1_q <= t1_d;
            hs1_q <= hs1_d; vs1_q <= vs1_d; blank1_q <= blank1_d;
            ro_q <= ro_d; go_q <= go_d; bo_q <= bo_d;
            hs2_q <= hs2_d; vs2_q <= vs2_d; blank2_q <= blank2_d;
        end
    end

    assign ro        = ro_q;
    assign go        = go_q;
    assign bo        = bo_q;
    assign hsync_n_o = hs2_q;
    assign vsync_n_o = vs2_q;
    assign blank_o   = blank2_q;

endmodule
